// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace capture buffer.
package pipe_trace_pkg;

  // Capture FSM encoding; values are visible on the state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // Width of one packed {pc, instr, res} sample record.
  function automatic int unsigned smp_width(input int unsigned pc_w,
                                            input int unsigned instr_w,
                                            input int unsigned res_w);
    return pc_w + instr_w + res_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Sample storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one sample per write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular capture buffer for retired-instruction samples with PC/forced trigger,
// programmable post-trigger window and oldest-first valid/ready readout.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               trig_pc_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               trig_force,
  input  logic [AW-1:0]      post_cnt,
  input  logic               smp_valid,
  input  logic [PC_W-1:0]    smp_pc,
  input  logic [INSTR_W-1:0] smp_instr,
  input  logic [RES_W-1:0]   smp_res,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               wrapped,
  output logic [AW:0]        count,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [RES_W-1:0]   rd_res,
  output logic               rd_last
);

  localparam int unsigned SW         = smp_width(PC_W, INSTR_W, RES_W);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  state_e         state_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    count_q;
  logic           triggered_q;
  logic           wrapped_q;
  logic [AW-1:0]  post_q;
  logic [AW-1:0]  remaining_q;

  logic           wr_en;
  logic           trig_hit;
  logic [AW-1:0]  rd_ptr;
  logic [SW-1:0]  rd_data;

  // Samples are stored only while capturing.
  always_comb begin
    wr_en    = smp_valid && ((state_q == ST_ARMED) || (state_q == ST_POST));
    trig_hit = (smp_valid && trig_pc_en && (smp_pc == trig_pc)) || trig_force;
  end

  // wr_ptr is frozen in READ and count drops by one per transfer, so the
  // oldest unread entry is always wr_ptr - count; no separate read pointer needed.
  assign rd_ptr = wr_ptr_q - count_q[AW-1:0];

  // Capture/readout FSM with pointer, occupancy and status bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      post_q      <= '0;
      remaining_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q == COUNT_FULL) begin
          wrapped_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
            post_q      <= post_cnt;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            triggered_q <= 1'b1;
            remaining_q <= post_q;
            state_q     <= (post_q == '0) ? ST_READ : ST_POST;
          end
        end
        ST_POST: begin
          if (smp_valid) begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == AW'(1)) begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (count_q == '0) begin
            state_q <= ST_IDLE;
          end else if (rd_ready) begin
            count_q <= count_q - 1'b1;
            if (count_q == (AW+1)'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({smp_pc, smp_instr, smp_res}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Status and read-port outputs derived from registered state.
  always_comb begin
    state     = state_q;
    triggered = triggered_q;
    wrapped   = wrapped_q;
    count     = count_q;
    rd_valid  = (state_q == ST_READ) && (count_q != '0);
    rd_last   = rd_valid && (count_q == (AW+1)'(1));
    rd_pc     = rd_data[SW-1 -: PC_W];
    rd_instr  = rd_data[RES_W +: INSTR_W];
    rd_res    = rd_data[RES_W-1:0];
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed, table-driven bench for pipe_trace_buffer (default parameters).
module tb_pipe_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        trig_pc_en;
  logic [7:0]  trig_pc;
  logic        trig_force;
  logic [3:0]  post_cnt;
  logic        smp_valid;
  logic [7:0]  smp_pc;
  logic [15:0] smp_instr;
  logic [7:0]  smp_res;
  logic [1:0]  state;
  logic        triggered;
  logic        wrapped;
  logic [4:0]  count;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_pc;
  logic [15:0] rd_instr;
  logic [7:0]  rd_res;
  logic        rd_last;

  int total = 0;
  int bad   = 0;

  pipe_trace_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trig_pc_en (trig_pc_en),
    .trig_pc    (trig_pc),
    .trig_force (trig_force),
    .post_cnt   (post_cnt),
    .smp_valid  (smp_valid),
    .smp_pc     (smp_pc),
    .smp_instr  (smp_instr),
    .smp_res    (smp_res),
    .state      (state),
    .triggered  (triggered),
    .wrapped    (wrapped),
    .count      (count),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_pc      (rd_pc),
    .rd_instr   (rd_instr),
    .rd_res     (rd_res),
    .rd_last    (rd_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] pc;
    logic       rdy;
    logic [1:0] st;
    logic [4:0] cnt;
    logic       rv;
    logic [7:0] rpc;
    logic       rl;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic sv, input logic [7:0] pc, input logic rdy,
                              input logic [1:0] st, input logic [4:0] cnt, input logic rv,
                              input logic [7:0] rpc, input logic rl);
    vec_t v;
    v.sv = sv; v.pc = pc; v.rdy = rdy; v.st = st;
    v.cnt = cnt; v.rv = rv; v.rpc = rpc; v.rl = rl;
    return v;
  endfunction

  function automatic logic [15:0] exp_instr(input logic [7:0] pc);
    return {pc, ~pc};
  endfunction

  function automatic logic [7:0] exp_res(input logic [7:0] pc);
    return pc + 8'h11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_smp(input logic v, input logic [7:0] pc);
    smp_valid = v;
    smp_pc    = pc;
    smp_instr = exp_instr(pc);
    smp_res   = exp_res(pc);
  endtask

  task automatic do_arm(input logic [3:0] post, input logic [7:0] tpc, input logic en);
    arm        = 1'b1;
    post_cnt   = post;
    trig_pc    = tpc;
    trig_pc_en = en;
    step();
    arm        = 1'b0;
  endtask

  // Arm for the basic capture and play the stimulus/expectation table.
  task automatic run_table(input string tag);
    do_arm(4'd2, 8'h03, 1'b1);
    chk({tag, "_armed"}, 32'(state), 32'd1);
    for (int i = 0; i < 12; i++) begin
      set_smp(tbl[i].sv, tbl[i].pc);
      rd_ready = tbl[i].rdy;
      step();
      chk($sformatf("%s_st%0d", tag, i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("%s_cnt%0d", tag, i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("%s_rv%0d", tag, i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("%s_rl%0d", tag, i), 32'(rd_last), 32'(tbl[i].rl));
      if (tbl[i].rv) begin
        chk($sformatf("%s_pc%0d", tag, i), 32'(rd_pc), 32'(tbl[i].rpc));
        chk($sformatf("%s_in%0d", tag, i), 32'(rd_instr), 32'(exp_instr(tbl[i].rpc)));
        chk($sformatf("%s_rs%0d", tag, i), 32'(rd_res), 32'(exp_res(tbl[i].rpc)));
      end
    end
    rd_ready = 1'b0;
    set_smp(1'b0, 8'h00);
    chk({tag, "_trig"}, 32'(triggered), 32'd1);
    chk({tag, "_wrap"}, 32'(wrapped), 32'd0);
  endtask

  // Basic capture without checks, leaving the buffer in READ with 6 entries.
  task automatic capture_basic();
    do_arm(4'd2, 8'h03, 1'b1);
    for (int p = 0; p < 6; p++) begin
      set_smp(1'b1, 8'(p));
      step();
    end
    set_smp(1'b0, 8'h00);
  endtask

  int idx;

  initial begin
    reset = 1'b0; arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0; trig_force = 1'b0;
    post_cnt = '0; rd_ready = 1'b0;
    set_smp(1'b0, 8'h00);

    tbl[0]  = mk(1'b1, 8'h00, 1'b0, 2'd1, 5'd1, 1'b0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b1, 8'h01, 1'b0, 2'd1, 5'd2, 1'b0, 8'h00, 1'b0);
    tbl[2]  = mk(1'b1, 8'h02, 1'b0, 2'd1, 5'd3, 1'b0, 8'h00, 1'b0);
    tbl[3]  = mk(1'b1, 8'h03, 1'b0, 2'd2, 5'd4, 1'b0, 8'h00, 1'b0);
    tbl[4]  = mk(1'b1, 8'h04, 1'b0, 2'd2, 5'd5, 1'b0, 8'h00, 1'b0);
    tbl[5]  = mk(1'b1, 8'h05, 1'b0, 2'd3, 5'd6, 1'b1, 8'h00, 1'b0);
    // Sample matching trig_pc during READ must be ignored.
    tbl[6]  = mk(1'b1, 8'h03, 1'b1, 2'd3, 5'd5, 1'b1, 8'h01, 1'b0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b1, 2'd3, 5'd4, 1'b1, 8'h02, 1'b0);
    tbl[8]  = mk(1'b0, 8'h00, 1'b1, 2'd3, 5'd3, 1'b1, 8'h03, 1'b0);
    tbl[9]  = mk(1'b0, 8'h00, 1'b1, 2'd3, 5'd2, 1'b1, 8'h04, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 1'b1, 2'd3, 5'd1, 1'b1, 8'h05, 1'b1);
    tbl[11] = mk(1'b0, 8'h00, 1'b1, 2'd0, 5'd0, 1'b0, 8'h00, 1'b0);

    step();
    step();
    reset = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rv", 32'(rd_valid), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_wrap", 32'(wrapped), 32'd0);

    // Sample while IDLE is dropped.
    set_smp(1'b1, 8'h77);
    step();
    set_smp(1'b0, 8'h00);
    chk("idle_count", 32'(count), 32'd0);

    run_table("basic");

    // Wrap: 25 samples stored into 16 entries, later samples ignored.
    do_arm(4'd4, 8'h14, 1'b1);
    for (int p = 0; p < 32; p++) begin
      set_smp(1'b1, 8'(p));
      step();
    end
    set_smp(1'b0, 8'h00);
    chk("wrap_state", 32'(state), 32'd3);
    chk("wrap_count", 32'(count), 32'd16);
    chk("wrap_wrapped", 32'(wrapped), 32'd1);
    chk("wrap_trig", 32'(triggered), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap_rv%0d", i), 32'(rd_valid), 32'd1);
      chk($sformatf("wrap_pc%0d", i), 32'(rd_pc), 32'(8'h09 + 8'(i)));
      chk($sformatf("wrap_rl%0d", i), 32'(rd_last), 32'(i == 15));
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    chk("wrap_idle", 32'(state), 32'd0);
    chk("wrap_hold", 32'(wrapped), 32'd1);

    // Backpressure with rd_ready pattern 1,0,0,...
    capture_basic();
    idx = 0;
    for (int k = 0; k < 40 && state != 2'd0; k++) begin
      rd_ready = (k % 3 == 0);
      if (rd_valid) begin
        chk($sformatf("bp_pc%0d", k), 32'(rd_pc), 32'(idx));
        chk($sformatf("bp_rl%0d", k), 32'(rd_last), 32'(idx == 5));
        chk($sformatf("bp_in%0d", k), 32'(rd_instr), 32'(exp_instr(8'(idx))));
        if (rd_ready) idx++;
      end
      step();
    end
    rd_ready = 1'b0;
    chk("bp_delivered", 32'(idx), 32'd6);
    chk("bp_idle", 32'(state), 32'd0);

    // Forced trigger after three samples, no post window.
    do_arm(4'd0, 8'h00, 1'b0);
    for (int p = 0; p < 3; p++) begin
      set_smp(1'b1, 8'(8'h40 + 8'(p)));
      step();
    end
    set_smp(1'b0, 8'h00);
    chk("force_armed", 32'(state), 32'd1);
    trig_force = 1'b1;
    step();
    trig_force = 1'b0;
    chk("force_state", 32'(state), 32'd3);
    chk("force_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("force_pc%0d", i), 32'(rd_pc), 32'(8'h40 + 8'(i)));
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    chk("force_idle", 32'(state), 32'd0);

    // Forced trigger right after arm: empty READ, straight back to IDLE.
    do_arm(4'd0, 8'h00, 1'b0);
    trig_force = 1'b1;
    step();
    trig_force = 1'b0;
    chk("empty_state", 32'(state), 32'd3);
    chk("empty_count", 32'(count), 32'd0);
    chk("empty_rv", 32'(rd_valid), 32'd0);
    step();
    chk("empty_idle", 32'(state), 32'd0);
    chk("empty_rv2", 32'(rd_valid), 32'd0);
    chk("empty_trig", 32'(triggered), 32'd1);

    // Reset mid-read after three transfers.
    capture_basic();
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("mid_count", 32'(count), 32'd3);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    rd_ready = 1'b0;
    chk("mid_state", 32'(state), 32'd0);
    chk("mid_cnt0", 32'(count), 32'd0);
    chk("mid_rv", 32'(rd_valid), 32'd0);
    chk("mid_trig", 32'(triggered), 32'd0);
    chk("mid_wrap", 32'(wrapped), 32'd0);

    run_table("again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Synthesisable, parametrised capture buffer for retired-instruction samples (PC, instruction, ALU result) from the pipelined processor core. It records samples into a circular buffer, stops a programmable number of samples after a PC-match or forced trigger, then streams the captured window out oldest-first over a valid/ready port. It sits beside the core top and replaces simulation-only $monitor tracing for on-chip and regression debug.

Parameters:
PC_W, 8, sample PC width
INSTR_W, 16, sample instruction width
RES_W, 8, sample ALU result width
DEPTH, 16, buffer entries; power of 2, >=4
AW, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
arm  in  1  start capture; honoured only in IDLE
trig_pc_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  trigger PC value
trig_force  in  1  immediate trigger, no sample required
post_cnt  in  AW  samples stored after trigger sample; latched on arm
smp_valid  in  1  sample present this cycle
smp_pc  in  PC_W  sample PC
smp_instr  in  INSTR_W  sample instruction
smp_res  in  RES_W  sample ALU result
state  out  2  0=IDLE 1=ARMED 2=POST 3=READ
triggered  out  1  trigger seen since last arm
wrapped  out  1  at least one entry overwritten since arm
count  out  AW+1  entries held, 0..DEPTH
rd_valid  out  1  read entry available
rd_ready  in  1  consumer accepts entry
rd_pc  out  PC_W  read PC
rd_instr  out  INSTR_W  read instruction
rd_res  out  RES_W  read result
rd_last  out  1  current read entry is final

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, wr_ptr=0, count=0, triggered=0, wrapped=0, latched post=0; rd_valid=0, rd_last=0. Storage array not reset; rd_pc/rd_instr/rd_res meaningful only while rd_valid. Reset wins over every other input in every state, including mid-read.
- IDLE: samples ignored. arm: next state ARMED, wr_ptr=0, count=0, triggered=0, wrapped=0, post latched. A sample in the arm cycle is not stored.
- ARMED: each smp_valid writes entry at wr_ptr; wr_ptr+1 mod DEPTH; count+1 saturating at DEPTH; write when count==DEPTH sets wrapped.
- Trigger in ARMED: (smp_valid && trig_pc_en && smp_pc==trig_pc) || trig_force. Triggering sample (if valid) is stored. triggered=1. latched post==0 -> READ next cycle; else POST, remaining=post.
- POST: each smp_valid stored as above, remaining-1; the store that takes remaining to 0 moves state to READ next cycle. trig_* ignored. Max window = trigger + DEPTH-1 post samples.
- READ: samples ignored. rd_ptr = wr_ptr - count (mod DEPTH) on entry. rd_valid = (count!=0); rd_* = entry[rd_ptr] combinational from storage; rd_last = (count==1). Transfer on rd_valid && rd_ready: rd_ptr+1, count-1. rd_* held stable while rd_valid && !rd_ready. After last transfer, or on entry with count==0: state=IDLE next cycle. triggered/wrapped hold until next arm.
- arm outside IDLE ignored. Simultaneous trig_force and smp_valid without PC match: sample stored, trigger taken.
- Latency: sample to storage 1 cycle; trigger to READ 1 cycle (post==0); rd_valid visible in the first READ cycle.

Decomposition:
- Package pipe_trace_pkg: state encoding constants (ST_IDLE, ST_ARMED, ST_POST, ST_READ), sample record width helper.
- Sub-module trace_ram: DEPTH x (PC_W+INSTR_W+RES_W) register file, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Reset: hold reset=0 two cycles mid-stream -> state=0, count=0, rd_valid=0, triggered=0, wrapped=0.
- Basic: arm, trig_pc_en=1, trig_pc=0x03, post_cnt=2, samples pc 0x00..0x05 -> state=3 after 0x05, count=6, read pcs 0x00..0x05 in order, rd_last only on 0x05, then IDLE.
- Wrap: DEPTH=16, post_cnt=4, trig_pc=0x14, pcs 0x00..0x1F -> capture stops after 0x18, count=16, wrapped=1, readout 0x09..0x18; samples 0x19..0x1F absent.
- Backpressure: basic capture with rd_ready toggling 1,0,0,1,... -> each entry delivered exactly once, in order, rd_* stable while stalled.
- Force trigger: arm, three samples, then trig_force with smp_valid=0, post_cnt=0 -> READ next cycle, count=3; arm then trig_force immediately -> READ with count=0, rd_valid never asserts, IDLE next cycle.
- Reset mid-read: reset=0 after 3 of 6 transfers -> next cycle IDLE, count=0, rd_valid=0; a fresh arm/trigger capture then behaves as in the basic case.
